vreg_file: RTL
==============

# vreg_file

Parametrised scalar/vector register file for the SIMD core, successor to the fixed 16×16-lane file. Holds a scalar bank and a vector bank of LANES-wide registers. Supports lane-masked, scalar, splat and lane-insert writes, plus a per-register pending-write scoreboard that gives decode a hazard/stall indication. It sits between decode (read ports, issue) and write-back (write port).

## Interface
- `LANES`, default 16: vector lanes; lane LANES-1 is the scalar/"primary" lane.
- `DATA_W`, default 32: bits per lane.
- `NREGS`, default 16: registers per bank, ≥8; `AW = $clog2(NREGS)`; index NREGS-1 in the scalar bank is the PC alias.
- `clk` in 1: single clock; all state updates on the falling edge.
- `rst` in 1: asynchronous, active-high reset.
- `ra1`, `ra2` in AW: read addresses.
- `rsel1`, `rsel2` in 1: bank for lane LANES-1 of each read port (0 scalar, 1 vector).
- `pc_in` in DATA_W: value returned for scalar reads of index NREGS-1.
- `we` in 1: write enable.
- `wmode` in 2: 00 vector masked, 01 scalar, 10 splat, 11 lane insert.
- `waddr` in AW: write register.
- `wlane` in $clog2(LANES): target lane for insert.
- `wmask` in LANES: lane mask for modes 00/10.
- `wd` in LANES×DATA_W: write data; lane LANES-1 is the scalar source.
- `iss` in 1: mark a register pending (producer issued).
- `iss_vec` in 1: bank of issued register.
- `iss_addr` in AW: issued register.
- `rd1`, `rd2` out LANES×DATA_W: read data.
- `busy1`, `busy2` out 1: addressed register (in bank `rsel`) has a pending write.
- `dbg_s0` out DATA_W: scalar register 0, for the debug probe.

## Operation
- State: `sreg[NREGS-1]` (scalar, index NREGS-1 not stored), `vreg[NREGS][LANES]`, `spend[NREGS]`, `vpend[NREGS]`.
- Reset (async, immediate): all sreg/vreg lanes 0, all pend bits 0, then vreg lane LANES-1 presets: [NREGS-1]=1, [NREGS-2]=16, [NREGS-3]=0, [NREGS-4]=16, [NREGS-5]=50.
- Read (combinational):
  - Lanes 0..LANES-2 are always vreg[ra][lane].
  - Lane LANES-1: rsel=1 gives vreg[ra][LANES-1]; rsel=0 and ra=NREGS-1 gives pc_in; otherwise sreg[ra].
- Write (falling edge, `we`=1):
  - 00: vreg[waddr][i] ← wd[i] for each i with wmask[i]=1; others hold; wmask=0 is a no-op.
  - 01: sreg[waddr] ← wd[LANES-1]; waddr=NREGS-1 is dropped (PC is read-only here).
  - 10: vreg[waddr][i] ← wd[LANES-1] for each i with wmask[i]=1.
  - 11: vreg[waddr][wlane] ← wd[LANES-1]; mask ignored; wlane ≥ LANES is a no-op.
- Scoreboard (falling edge):
  - A write clears the pend bit of its bank/waddr: modes 01 → spend, others → vpend. This applies even when the mask is 0 or the write is otherwise dropped.
  - `iss` sets pend[iss_vec][iss_addr]. `iss` to scalar NREGS-1 is ignored.
  - Same edge, same register, both write and iss: set wins (new producer); the data write still occurs.
  - busyN = (rselN ? vpend : spend)[raN]; scalar NREGS-1 is never busy.

## Timing
- Read latency 0 (combinational from ra/rsel/state).
- Write-to-read: data written on falling edge n is visible on rd from that edge; decode sampling on the next rising edge sees new data (same-cycle write-then-read).
- busy reflects scoreboard updates from the same falling edge.
- Reset mid-write: reset dominates; no partial update survives.
- dbg_s0 is a register output view of sreg[0] (0 after reset).

## Test plan
- Reset → rd1 with ra1=NREGS-1, rsel1=1 gives lane LANES-1=1; NREGS-5 gives 50; all other lanes 0; busy1=busy2=0; dbg_s0=0.
- Vector write mode 00, waddr=2, wmask=0x00FF, wd[i]=i+100 → vreg[2] lanes 0..7 = 100..107, lanes 8..15 = 0; read via rd2 same cycle after the falling edge.
- Scalar write mode 01, waddr=0, wd[15]=0xDEAD → dbg_s0=0xDEAD; read rsel=0 ra=0 gives 0xDEAD in lane 15 and vreg[0] in lanes 0..14. Scalar write to waddr=15 is dropped; read ra=15 rsel=0 returns pc_in=0x40.
- Splat mode 10, wd[15]=7, wmask=all 1 → all lanes of vreg[3]=7. Insert mode 11, wlane=5, wd[15]=9 → only lane 5 changes to 9.
- iss vec reg 4 → busy1=1 for ra1=4, rsel1=1, and busy=0 for rsel1=0. Vector write to 4 → busy clears. Simultaneous iss and write to 4 → busy stays 1 and data updated.
- Assert rst during a write cycle with we=1 → all registers return to reset presets and pend bits are 0.

Source files
------------

// File: rtl/vreg_file.sv
// Scalar/vector register file for the SIMD core: falling-edge writes, combinational
// reads, and a per-register pending-write scoreboard for decode hazard checks.
module vreg_file #(
    parameter int unsigned LANES  = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREGS  = 16
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [$clog2(NREGS)-1:0]                      ra1,
    input  logic [$clog2(NREGS)-1:0]                      ra2,
    input  logic                                          rsel1,
    input  logic                                          rsel2,
    input  logic [DATA_W-1:0]                             pc_in,
    input  logic                                          we,
    input  logic [1:0]                                    wmode,
    input  logic [$clog2(NREGS)-1:0]                      waddr,
    input  logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0]  wlane,
    input  logic [LANES-1:0]                              wmask,
    input  logic [LANES*DATA_W-1:0]                       wd,
    input  logic                                          iss,
    input  logic                                          iss_vec,
    input  logic [$clog2(NREGS)-1:0]                      iss_addr,
    output logic [LANES*DATA_W-1:0]                       rd1,
    output logic [LANES*DATA_W-1:0]                       rd2,
    output logic                                          busy1,
    output logic                                          busy2,
    output logic [DATA_W-1:0]                             dbg_s0
);

    localparam int unsigned AW = $clog2(NREGS);
    localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [AW-1:0] PC_IDX = AW'(NREGS - 1);

    localparam logic [1:0] MODE_VEC    = 2'b00;
    localparam logic [1:0] MODE_SCALAR = 2'b01;
    localparam logic [1:0] MODE_SPLAT  = 2'b10;
    localparam logic [1:0] MODE_INSERT = 2'b11;

    // Scalar bank has no storage for the PC alias index.
    logic [DATA_W-1:0] sreg [NREGS-1];
    logic [DATA_W-1:0] vreg [NREGS][LANES];
    logic [NREGS-1:0]  spend;
    logic [NREGS-1:0]  vpend;
    logic [DATA_W-1:0] wd_s;

    assign wd_s   = wd[(LANES-1)*DATA_W +: DATA_W];
    assign dbg_s0 = sreg[0];

    // Register data storage, written on the falling edge.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < int'(NREGS) - 1; r++) begin
                sreg[r] <= '0;
            end
            for (int r = 0; r < int'(NREGS); r++) begin
                for (int i = 0; i < int'(LANES); i++) begin
                    vreg[r][i] <= '0;
                end
            end
            vreg[NREGS-1][LANES-1] <= DATA_W'(1);
            vreg[NREGS-2][LANES-1] <= DATA_W'(16);
            vreg[NREGS-4][LANES-1] <= DATA_W'(16);
            vreg[NREGS-5][LANES-1] <= DATA_W'(50);
        end else if (we) begin
            case (wmode)
                MODE_VEC: begin
                    for (int i = 0; i < int'(LANES); i++) begin
                        if (wmask[i]) vreg[waddr][i] <= wd[i*DATA_W +: DATA_W];
                    end
                end
                MODE_SCALAR: begin
                    if (waddr != PC_IDX) sreg[waddr] <= wd_s;
                end
                MODE_SPLAT: begin
                    for (int i = 0; i < int'(LANES); i++) begin
                        if (wmask[i]) vreg[waddr][i] <= wd_s;
                    end
                end
                MODE_INSERT: begin
                    // Out-of-range lane numbers match no lane and drop the write.
                    for (int i = 0; i < int'(LANES); i++) begin
                        if (wlane == LW'(i)) vreg[waddr][i] <= wd_s;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pending-write scoreboard: a write clears, an issue sets, and the later set wins.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            spend <= '0;
            vpend <= '0;
        end else begin
            if (we) begin
                if (wmode == MODE_SCALAR) begin
                    if (waddr != PC_IDX) spend[waddr] <= 1'b0;
                end else begin
                    vpend[waddr] <= 1'b0;
                end
            end
            if (iss) begin
                if (iss_vec) begin
                    vpend[iss_addr] <= 1'b1;
                end else if (iss_addr != PC_IDX) begin
                    spend[iss_addr] <= 1'b1;
                end
            end
        end
    end

    // Combinational read ports; the top lane selects scalar bank, PC alias or vector bank.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        for (int i = 0; i < int'(LANES) - 1; i++) begin
            rd1[i*DATA_W +: DATA_W] = vreg[ra1][i];
            rd2[i*DATA_W +: DATA_W] = vreg[ra2][i];
        end
        if (rsel1)              rd1[(LANES-1)*DATA_W +: DATA_W] = vreg[ra1][LANES-1];
        else if (ra1 == PC_IDX) rd1[(LANES-1)*DATA_W +: DATA_W] = pc_in;
        else                    rd1[(LANES-1)*DATA_W +: DATA_W] = sreg[ra1];
        if (rsel2)              rd2[(LANES-1)*DATA_W +: DATA_W] = vreg[ra2][LANES-1];
        else if (ra2 == PC_IDX) rd2[(LANES-1)*DATA_W +: DATA_W] = pc_in;
        else                    rd2[(LANES-1)*DATA_W +: DATA_W] = sreg[ra2];
    end

    // The PC alias index never gets a scalar pend bit, so it never reports busy.
    assign busy1 = rsel1 ? vpend[ra1] : spend[ra1];
    assign busy2 = rsel2 ? vpend[ra2] : spend[ra2];

endmodule
